// File: rtl/reg_read_serializer.sv
// Burst reader for a small register bank: fetches consecutive words
// (address wraps at the top of the bank) and streams each one out
// MSB first on a single serial line. All state moves on the falling
// edge of inClk; inClr is an asynchronous, active-high clear.
//
// Serial handshake: a bit is transferred on every cycle where
// outSerValid is high. inStall acts as the sink's "not ready": while it
// is high, outSerValid drops, outSer keeps showing the pending bit and
// nothing advances, so every stalled cycle adds exactly one cycle to
// the burst.
module reg_read_serializer #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                     inClk,
    input  logic                     inClr,
    input  logic                     inStart,
    input  logic [$clog2(DEPTH)-1:0] inFirst,
    input  logic [3:0]               inCount,
    input  logic                     inStall,
    input  logic [WIDTH-1:0]         inData,
    output logic [$clog2(DEPTH)-1:0] outAddr,
    output logic                     outSer,
    output logic                     outSerValid,
    output logic                     outWordEnd,
    output logic                     outBusy,
    output logic                     outDone,
    output logic [1:0]               dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(WIDTH);
    localparam logic [3:0]    MAX_CNT  = 4'(DEPTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [3:0]      rem_q, rem_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;

    // State register: falling-edge capture, asynchronous clear to IDLE.
    always_ff @(negedge inClk or posedge inClr) begin
        if (inClr) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Next-state logic: burst acceptance, word fetch, bit shifting, word sequencing.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                // A zero-length request is dropped silently.
                if (inStart && (inCount != 4'd0)) begin
                    rem_d   = (inCount > MAX_CNT) ? MAX_CNT : inCount;
                    addr_d  = inFirst;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // Bank data is only sampled here; later changes are ignored.
                shift_d   = inData;
                bit_cnt_d = LAST_BIT;
                state_d   = S_SHIFT;
            end
            S_SHIFT: begin
                if (!inStall) begin
                    shift_d   = {shift_q[WIDTH-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q - 1'b1;
                    if (bit_cnt_q == '0) begin
                        rem_d = rem_q - 1'b1;
                        if (rem_q > 4'd1) begin
                            addr_d  = addr_q + 1'b1;
                            state_d = S_LOAD;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode: serial outputs only live in SHIFT, status from the state.
    always_comb begin
        outSer      = 1'b0;
        outSerValid = 1'b0;
        outWordEnd  = 1'b0;
        if (state_q == S_SHIFT) begin
            outSer      = shift_q[WIDTH-1];
            outSerValid = !inStall;
            outWordEnd  = (bit_cnt_q == '0) && !inStall;
        end
        outBusy = (state_q != S_IDLE);
        outDone = (state_q == S_DONE);
    end

    assign outAddr   = addr_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_reg_read_serializer.sv
// Bench for reg_read_serializer. A transaction-level model turns each
// burst request (bank contents, first address, count, stall window)
// into the cycle-by-cycle output stream the block must produce; one
// compare process checks the DUT against that stream on the rising
// edge (the block moves on the falling edge). Inputs change 1 time unit
// after each falling edge.
module tb_reg_read_serializer;

    localparam int W = 9;  // {chk_ser, busy, addr[2:0], ser, valid, wend, done}

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [2:0]  first;
    logic [3:0]  count;
    logic        stall;
    logic [15:0] data;
    logic [2:0]  addr;
    logic        ser, ser_valid, word_end, busy, done;
    logic [1:0]  dbg_state;

    logic [15:0] bank [8];
    logic        junk_en;
    logic [15:0] junk_val;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] plan_exp[$];
    logic [2:0]   plan_stim[$];  // {start_pulse, stall, junk_data}
    logic [2:0]   plan_end_addr;
    logic [2:0]   model_addr;

    int          tally_cyc, valid_cnt, wend_cnt, done_cyc;
    logic [15:0] ser_acc;
    logic [2:0]  addr_seen[$];

    reg_read_serializer dut (
        .inClk      (clk),
        .inClr      (clr),
        .inStart    (start),
        .inFirst    (first),
        .inCount    (count),
        .inStall    (stall),
        .inData     (data),
        .outAddr    (addr),
        .outSer     (ser),
        .outSerValid(ser_valid),
        .outWordEnd (word_end),
        .outBusy    (busy),
        .outDone    (done),
        .dbg_state  (dbg_state)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Bank read port; during SHIFT cycles the bench feeds garbage to prove
    // the data is only taken at the load edge.
    assign data = junk_en ? junk_val : bank[addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic chk, input logic b, input logic [2:0] a,
                                        input logic s, input logic v, input logic we, input logic d);
        return {chk, b, a, s, v, we, d};
    endfunction

    // Model: expected per-cycle outputs of a burst, starting with the cycle
    // after the start is sampled and ending with the DONE cycle.
    task automatic gen_burst(input logic [2:0] f, input logic [3:0] c, input int st_word,
                             input int st_bit, input int st_len, input int busy_start_idx);
        int n;
        logic [15:0] w;
        logic [2:0] a;
        plan_exp.delete();
        plan_stim.delete();
        n = (int'(c) > 8) ? 8 : int'(c);
        a = f;
        for (int i = 0; i < n; i++) begin
            a = 3'((int'(f) + i) % 8);
            w = bank[a];
            plan_exp.push_back(mk(1'b0, 1'b1, a, 1'b0, 1'b0, 1'b0, 1'b0));
            plan_stim.push_back(3'b000);
            for (int b = 15; b >= 0; b--) begin
                if (i == st_word && b == st_bit) begin
                    for (int s = 0; s < st_len; s++) begin
                        plan_exp.push_back(mk(1'b1, 1'b1, a, w[b], 1'b0, 1'b0, 1'b0));
                        plan_stim.push_back(3'b011);
                    end
                end
                plan_exp.push_back(mk(1'b1, 1'b1, a, w[b], 1'b1, (b == 0), 1'b0));
                plan_stim.push_back(3'b001);
            end
        end
        plan_exp.push_back(mk(1'b0, 1'b1, a, 1'b0, 1'b0, 1'b0, 1'b1));
        plan_stim.push_back(3'b000);
        if (busy_start_idx >= 0) plan_stim[busy_start_idx] = plan_stim[busy_start_idx] | 3'b100;
        plan_end_addr = a;
    endtask

    task automatic reset_tally();
        tally_cyc = 0;
        valid_cnt = 0;
        wend_cnt  = 0;
        done_cyc  = 0;
        ser_acc   = '0;
        addr_seen.delete();
    endtask

    function automatic logic [W-1:0] idle_rec();
        return mk(1'b0, 1'b0, model_addr, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    // Driver: replays the current plan; abort_at >= 0 pulls inClr at that cycle.
    task automatic run_burst(input logic [2:0] f, input logic [3:0] c, input int abort_at);
        bit aborted = 0;
        @(negedge clk); #1;
        start = 1'b1; first = f; count = c; stall = 1'b0; junk_en = 1'b0;
        exp_q.push_back(idle_rec());
        for (int k = 0; k < plan_exp.size(); k++) begin
            @(negedge clk); #1;
            if (k == abort_at) begin
                aborted = 1;
                break;
            end
            if (k == 0) reset_tally();
            start    = plan_stim[k][2];
            first    = plan_stim[k][2] ? 3'd5 : f;
            stall    = plan_stim[k][1];
            junk_en  = plan_stim[k][0];
            junk_val = 16'($urandom);
            exp_q.push_back(plan_exp[k]);
        end
        start = 1'b0; stall = 1'b0; junk_en = 1'b0;
        if (aborted) begin
            clr = 1'b1;
            #1;
            check("rst_mid_outputs", {26'd0, addr, ser, ser_valid, word_end, busy, done}, 32'd0);
            check("rst_mid_state", {30'd0, dbg_state}, 32'd0);
            model_addr = 3'd0;
            exp_q.push_back(idle_rec());
            @(negedge clk); #1;
            clr = 1'b0;
            exp_q.push_back(idle_rec());
        end else begin
            model_addr = plan_end_addr;
            @(negedge clk); #1;
            exp_q.push_back(idle_rec());
        end
    endtask

    // Compare process: checks every cycle the model has a record for, and
    // keeps tallies used by the hand-computed checks.
    always @(posedge clk) begin
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tally_cyc++;
            check("busy", {31'd0, busy}, {31'd0, e[7]});
            check("addr", {29'd0, addr}, {29'd0, e[6:4]});
            check("ser_valid", {31'd0, ser_valid}, {31'd0, e[2]});
            check("word_end", {31'd0, word_end}, {31'd0, e[1]});
            check("done", {31'd0, done}, {31'd0, e[0]});
            if (e[8]) check("ser", {31'd0, ser}, {31'd0, e[3]});
            if (ser_valid) begin
                valid_cnt++;
                ser_acc = {ser_acc[14:0], ser};
            end
            if (word_end) begin
                wend_cnt++;
                addr_seen.push_back(addr);
            end
            if (done) done_cyc = tally_cyc;
        end
    end

    // Watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // Directed sequence.
    initial begin
        logic [15:0] acc;
        logic [8:0]  seq;
        clr = 1'b1; start = 1'b0; first = 3'd0; count = 4'd0; stall = 1'b0;
        junk_en = 1'b0; junk_val = '0;
        model_addr = 3'd0;
        bank[0] = 16'h1234; bank[1] = 16'h8001; bank[2] = 16'hA5C3; bank[3] = 16'h0F0F;
        bank[4] = 16'hFFFF; bank[5] = 16'h5A5A; bank[6] = 16'hC001; bank[7] = 16'h7FFE;
        reset_tally();
        #1;
        check("reset_outputs", {26'd0, addr, ser, ser_valid, word_end, busy, done}, 32'd0);
        @(negedge clk); #1;
        @(negedge clk); #1;
        clr = 1'b0;
        exp_q.push_back(idle_rec());

        // Single word from address 2.
        gen_burst(3'd2, 4'd1, -1, 0, 0, -1);
        check("model_len_single", plan_exp.size(), 32'd18);
        acc = '0;
        foreach (plan_exp[i]) if (plan_exp[i][2]) acc = {acc[14:0], plan_exp[i][3]};
        check("model_bits_single", {16'd0, acc}, 32'h0000A5C3);
        run_burst(3'd2, 4'd1, -1);
        check("single_stream", {16'd0, ser_acc}, 32'h0000A5C3);
        check("single_valid_cnt", valid_cnt, 32'd16);
        check("single_wend_cnt", wend_cnt, 32'd1);
        check("single_done_cyc", done_cyc, 32'd18);

        // Wrap burst 6,7,0.
        gen_burst(3'd6, 4'd3, -1, 0, 0, -1);
        check("model_len_wrap", plan_exp.size(), 32'd52);
        run_burst(3'd6, 4'd3, -1);
        check("wrap_valid_cnt", valid_cnt, 32'd48);
        check("wrap_wend_cnt", wend_cnt, 32'd3);
        check("wrap_done_cyc", done_cyc, 32'd52);
        seq = (addr_seen.size() == 3) ? {addr_seen[0], addr_seen[1], addr_seen[2]} : 9'h1FF;
        check("wrap_addr_seq", {23'd0, seq}, {23'd0, 9'b110_111_000});

        // Three stalled cycles in the middle of the all-ones word.
        gen_burst(3'd4, 4'd1, 0, 8, 3, -1);
        check("model_len_stall", plan_exp.size(), 32'd21);
        run_burst(3'd4, 4'd1, -1);
        check("stall_done_cyc", done_cyc, 32'd21);
        check("stall_valid_cnt", valid_cnt, 32'd16);

        // Zero-length request: nothing happens.
        reset_tally();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            start = 1'b1; first = 3'd7; count = 4'd0;
            exp_q.push_back(idle_rec());
        end
        @(negedge clk); #1;
        start = 1'b0;
        exp_q.push_back(idle_rec());
        @(negedge clk); #1;
        exp_q.push_back(idle_rec());
        check("zero_cnt_valid", valid_cnt, 32'd0);
        check("zero_cnt_done", done_cyc, 32'd0);

        // Oversized count clamps to a full 8-word sweep.
        gen_burst(3'd1, 4'd12, -1, 0, 0, -1);
        check("model_len_clamp", plan_exp.size(), 32'd137);
        run_burst(3'd1, 4'd12, -1);
        check("clamp_valid_cnt", valid_cnt, 32'd128);
        check("clamp_wend_cnt", wend_cnt, 32'd8);
        check("clamp_done_cyc", done_cyc, 32'd137);

        // Start pulse with a different address while shifting is ignored.
        gen_burst(3'd3, 4'd2, -1, 0, 0, 10);
        run_burst(3'd3, 4'd2, -1);
        seq = (addr_seen.size() == 2) ? {3'd0, addr_seen[0], addr_seen[1]} : 9'h1FF;
        check("busy_start_addr_seq", {23'd0, seq}, {23'd0, 9'b000_011_100});
        check("busy_start_done_cyc", done_cyc, 32'd35);

        // Reset during the second word of a 4-word burst, then a fresh burst.
        gen_burst(3'd0, 4'd4, -1, 0, 0, -1);
        run_burst(3'd0, 4'd4, 22);
        check("abort_no_done", done_cyc, 32'd0);
        gen_burst(3'd2, 4'd1, -1, 0, 0, -1);
        run_burst(3'd2, 4'd1, -1);
        check("after_rst_stream", {16'd0, ser_acc}, 32'h0000A5C3);
        check("after_rst_done_cyc", done_cyc, 32'd18);

        @(negedge clk); #1;
        exp_q.push_back(idle_rec());
        @(negedge clk); #1;
        check("final_queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_read_serializer.md
REG_READ_SERIALIZER -- requirements
Module: reg_read_serializer

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of 16-bit words in the attached register bank; address width is 3.
REQ-002 SHALL have parameter WIDTH, default 16: bits per word.
REQ-003 SHALL have port inClk, input, 1: clock; all state captures on the falling edge.
REQ-004 SHALL have port inClr, input, 1: reset inClr, asynchronous, active-high.
REQ-005 SHALL have port inStart, input, 1: read-burst request, sampled in IDLE only.
REQ-006 SHALL have port inFirst, input, 3: first bank address of the burst.
REQ-007 SHALL have port inCount, input, 4: number of words in the burst, legal range 1..8.
REQ-008 SHALL have port inStall, input, 1: serial backpressure; while high, shifting freezes.
REQ-009 SHALL have port inData, input, 16: bank read data, combinationally valid for the current outAddr.
REQ-010 SHALL have port outAddr, output, 3: bank read address.
REQ-011 SHALL have port outSer, output, 1: serial data, MSB first.
REQ-012 SHALL have port outSerValid, output, 1: outSer carries a valid bit this cycle.
REQ-013 SHALL have port outWordEnd, output, 1: high during the last bit (bit 0) of each word.
REQ-014 SHALL have port outBusy, output, 1: burst in progress.
REQ-015 SHALL have port outDone, output, 1: one-cycle burst-complete pulse.

Function
REQ-016 SHALL implement states IDLE, LOAD, SHIFT and DONE; outBusy SHALL be high in LOAD, SHIFT and DONE.
REQ-017 In IDLE with inStart=1 and inCount!=0, SHALL latch inCount into a remaining-word counter, set outAddr=inFirst and go to LOAD.
REQ-018 In IDLE with inStart=1 and inCount=0, SHALL stay in IDLE with no output change and no outDone.
REQ-019 inCount values 9..15 SHALL be clamped to 8.
REQ-020 LOAD SHALL last exactly one cycle: capture inData into a 16-bit shift register, set the bit counter to 15, then go to SHIFT.
REQ-021 In SHIFT, outSer SHALL equal shift-register bit 15, and outSerValid SHALL equal NOT inStall.
REQ-022 In SHIFT, each edge with inStall=0 SHALL shift left by one and decrement the bit counter; with inStall=1, all state SHALL hold.
REQ-023 In SHIFT, outWordEnd SHALL be high when the bit counter is 0 and inStall=0.
REQ-024 At an edge with bit counter 0 and inStall=0 and remaining>1, SHALL set outAddr=outAddr+1 (7 wraps to 0), decrement remaining, and go to LOAD.
REQ-025 At an edge with bit counter 0 and inStall=0 and remaining=1, SHALL go to DONE.
REQ-026 DONE SHALL last one cycle with outDone=1, then return to IDLE.
REQ-027 inStart SHALL be ignored in every state except IDLE.
REQ-028 inData SHALL be sampled only at the LOAD edge; changes to inData during SHIFT SHALL have no effect.
REQ-029 Without stalls, the first valid bit SHALL appear 2 cycles after the inStart sample edge, and each word SHALL take 17 cycles (1 LOAD + 16 SHIFT).
REQ-030 Without stalls, outDone SHALL assert 17*N+1 cycles after the inStart sample edge, where N is the burst length in words.
REQ-031 Each stalled cycle SHALL add exactly one cycle to the total burst latency.
REQ-032 outSerValid and outWordEnd SHALL be low in IDLE, LOAD and DONE.

Reset
REQ-033 inClr=1 SHALL immediately force state=IDLE, outAddr=0, outSer=0, outSerValid=0, outWordEnd=0, outBusy=0, outDone=0, and clear all counters and the shift register.
REQ-034 inClr asserted mid-burst SHALL abort the burst without any outDone pulse; after release, the block SHALL accept a new inStart from IDLE.

Verification
REQ-035 Single word: bank[2]=16'hA5C3, inFirst=2, inCount=1, no stall -> outSer serial stream 1010010111000011 with outSerValid high for 16 cycles, outWordEnd on the 16th bit, outDone 18 cycles after start.
REQ-036 Wrap burst: inFirst=6, inCount=3 -> outAddr sequence 6,7,0; 48 valid bits total; three outWordEnd pulses; outDone at cycle 52.
REQ-037 Stall: during word 16'hFFFF, hold inStall=1 for 3 cycles mid-word -> outSer frozen, outSerValid=0 for those 3 cycles, outDone delayed by exactly 3 cycles.
REQ-038 Count edge cases: inCount=0 -> no busy and no done; inCount=12 -> exactly 8 words output.
REQ-039 Reset mid-burst: assert inClr during word 2 of a 4-word burst -> all outputs 0 immediately, no outDone; a new burst started after release completes correctly.
REQ-040 Start while busy: pulse inStart with different inFirst during SHIFT -> ignored; addresses follow the original burst.
